ks_sub_pipe: RTL and testbench

KS_SUB_PIPE -- requirements
Module: ks_sub_pipe

---
 rtl/ks_sub_pipe.sv | 138 +++++++++++++
 tb/tb_ks_sub_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_sub_pipe.sv
// 3-stage Kogge-Stone add/sub pipeline with valid/ready flow control.
// Optional o_ovf/o_zero flags when KS_SUB_FLAGS_EN is defined.
module ks_sub_pipe (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_sub,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_tag,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_res,
    output logic        o_cout,
    output logic [3:0]  o_tag
`ifdef KS_SUB_FLAGS_EN
    ,
    output logic        o_ovf,
    output logic        o_zero
`endif
);

    function automatic logic [31:0] ks_g(
        input logic [31:0] g,
        input logic [31:0] p,
        input int          d
    );
        logic [31:0] gn;
        gn = g;
        for (int i = d; i < 32; i++)
            gn[i] = g[i] | (p[i] & g[i-d]);
        return gn;
    endfunction

    function automatic logic [31:0] ks_p(
        input logic [31:0] p,
        input int          d
    );
        logic [31:0] pn;
        pn = p;
        for (int i = d; i < 32; i++)
            pn[i] = p[i] & p[i-d];
        return pn;
    endfunction

    logic        adv;
    logic [31:0] bx;

    logic        v1, c0_1;
    logic [31:0] p1, g1;
    logic [3:0]  tag1;

    logic        v2, c0_2;
    logic [31:0] p2, gg2, gp2;
    logic [3:0]  tag2;

    logic [31:0] s2_gs, s2_g1, s2_p1, s2_g2, s2_p2, s2_g4, s2_p4;
    logic [31:0] s3_g8, s3_p8, s3_g16, s3_sum;

    assign adv     = ~o_valid | i_ready;
    assign o_ready = adv;
    assign bx      = i_b ^ {32{i_sub}};

    // Carry-in folded into bit 0 generate so the prefix tree sees it
    always_comb begin
        s2_gs    = g1;
        s2_gs[0] = g1[0] | (p1[0] & c0_1);
    end

    assign s2_g1 = ks_g(s2_gs, p1, 1);
    assign s2_p1 = ks_p(p1, 1);
    assign s2_g2 = ks_g(s2_g1, s2_p1, 2);
    assign s2_p2 = ks_p(s2_p1, 2);
    assign s2_g4 = ks_g(s2_g2, s2_p2, 4);
    assign s2_p4 = ks_p(s2_p2, 4);

    assign s3_g8  = ks_g(gg2, gp2, 8);
    assign s3_p8  = ks_p(gp2, 8);
    assign s3_g16 = ks_g(s3_g8, s3_p8, 16);
    assign s3_sum = p2 ^ {s3_g16[30:0], c0_2};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1      <= 1'b0;
            c0_1    <= 1'b0;
            p1      <= '0;
            g1      <= '0;
            tag1    <= '0;
            v2      <= 1'b0;
            c0_2    <= 1'b0;
            p2      <= '0;
            gg2     <= '0;
            gp2     <= '0;
            tag2    <= '0;
            o_valid <= 1'b0;
            o_res   <= '0;
            o_cout  <= 1'b0;
            o_tag   <= '0;
        end else if (adv) begin
            v1      <= i_valid;
            c0_1    <= i_sub;
            p1      <= i_a ^ bx;
            g1      <= i_a & bx;
            tag1    <= i_tag;
            v2      <= v1;
            c0_2    <= c0_1;
            p2      <= p1;
            gg2     <= s2_g4;
            gp2     <= s2_p4;
            tag2    <= tag1;
            o_valid <= v2;
            o_res   <= s3_sum;
            o_cout  <= s3_g16[31];
            o_tag   <= tag2;
        end
    end

`ifdef KS_SUB_FLAGS_EN
    logic a31_1, a31_2;

    // Operand signs agree when p[31] is clear; overflow if sum sign != a sign
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a31_1  <= 1'b0;
            a31_2  <= 1'b0;
            o_ovf  <= 1'b0;
            o_zero <= 1'b0;
        end else if (adv) begin
            a31_1  <= i_a[31];
            a31_2  <= a31_1;
            o_ovf  <= ~p2[31] & (s3_sum[31] ^ a31_2);
            o_zero <= (s3_sum == 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_ks_sub_pipe.sv
// Randomized self-checking bench for ks_sub_pipe.
// Queue-based reference model; directed latency/stall/reset cases.
module tb_ks_sub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_sub = 1'b0;
    logic [31:0] i_a = '0;
    logic [31:0] i_b = '0;
    logic [3:0]  i_tag = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_res;
    logic        o_cout;
    logic [3:0]  o_tag;
`ifdef KS_SUB_FLAGS_EN
    logic        o_ovf;
    logic        o_zero;
`endif

    ks_sub_pipe dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_sub   (i_sub),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_tag   (i_tag),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_res   (o_res),
        .o_cout  (o_cout),
        .o_tag   (o_tag)
`ifdef KS_SUB_FLAGS_EN
        ,
        .o_ovf   (o_ovf),
        .o_zero  (o_zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        cout;
        logic [3:0]  tag;
        logic        ovf;
        logic        zero;
    } exp_t;

    exp_t        q[$];
    logic [3:0]  seen_tags[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    bit          mon_en = 1'b0;
    bit          record = 1'b0;
    bit          hold = 1'b0;
    logic [37:0] held;

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic [3:0] tag);
        exp_t        e;
        logic [32:0] s;
        logic [31:0] bb;
        bb     = b ^ {32{sub}};
        s      = {1'b0, a} + {1'b0, bb} + {32'd0, sub};
        e.res  = s[31:0];
        e.cout = s[32];
        e.tag  = tag;
        e.ovf  = (a[31] == bb[31]) && (s[31] != a[31]);
        e.zero = (s[31:0] == 32'd0);
        return e;
    endfunction

    // Compare process: handshakes are evaluated on the negedge, inputs
    // change only just after the posedge.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (hold) begin
                check("stall_frozen", {o_valid, o_cout, o_tag, o_res}, held);
                hold = 1'b0;
            end
            if (o_valid && !i_ready) begin
                held = {o_valid, o_cout, o_tag, o_res};
                hold = 1'b1;
            end
            check("ready_rule", o_ready, !o_valid || i_ready);
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    check("spurious_result", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("res", o_res, e.res);
                    check("cout", o_cout, e.cout);
                    check("tag", o_tag, e.tag);
`ifdef KS_SUB_FLAGS_EN
                    check("ovf", o_ovf, e.ovf);
                    check("zero", o_zero, e.zero);
`endif
                    if (record) seen_tags.push_back(o_tag);
                end
            end
            if (i_valid && o_ready)
                q.push_back(model(i_a, i_b, i_sub, i_tag));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string nm, input logic [31:0] a,
                           input logic [31:0] b, input logic sub,
                           input logic [3:0] tag, input logic [31:0] er,
                           input logic ec, input logic eo, input logic ez);
        int k;
        i_a = a; i_b = b; i_sub = sub; i_tag = tag;
        i_valid = 1'b1; i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        k = 1;
        @(negedge clk);
        while (!o_valid && k < 8) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_latency"}, k, 3);
        check({nm, "_res"}, o_res, er);
        check({nm, "_cout"}, o_cout, ec);
        check({nm, "_tag"}, o_tag, tag);
`ifdef KS_SUB_FLAGS_EN
        check({nm, "_ovf"}, o_ovf, eo);
        check({nm, "_zero"}, o_zero, ez);
`else
        if (eo && ez) i_tag = '0;
`endif
        tick();
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int idx;
        int acc;
        int cyc;
        #1 rst_n = 1'b0;
        #2;
        check("rst_valid", o_valid, 0);
        check("rst_res", o_res, 0);
        check("rst_cout", o_cout, 0);
        check("rst_tag", o_tag, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", o_ready, 1);
        tick();
        mon_en = 1'b1;

        run_one("sub5_3", 32'h5, 32'h3, 1'b1, 4'h1, 32'h2, 1'b1, 1'b0, 1'b0);
        run_one("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 4'h2,
                32'h0, 1'b1, 1'b0, 1'b1);
        run_one("ovf", 32'h8000_0000, 32'h1, 1'b1, 4'h3,
                32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_one("sub_b0", 32'h1234_5678, 32'h0, 1'b1, 4'h4,
                32'h1234_5678, 1'b1, 1'b0, 1'b0);
        run_one("borrow", 32'h3, 32'h5, 1'b1, 4'h5,
                32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

        // Back-to-back stream with a three-cycle downstream stall
        record = 1'b1;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            i_ready = !(c >= 4 && c <= 6);
            i_valid = (idx < 8);
            i_a = $urandom; i_b = $urandom; i_sub = $urandom_range(0, 1);
            i_tag = idx[3:0];
            @(negedge clk);
            if (c >= 4 && c <= 6) check("stall_ready_low", o_ready, 0);
            acc = (i_valid && o_ready) ? 1 : 0;
            tick();
            idx += acc;
        end
        i_valid = 1'b0; i_ready = 1'b1;
        record = 1'b0;
        check("stream_accepted", idx, 8);
        check("stream_count", seen_tags.size(), 8);
        for (int i = 0; i < seen_tags.size(); i++)
            check("stream_order", seen_tags[i], i);

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1; i_a = $urandom; i_b = $urandom;
            i_tag = 4'(9 + i);
            tick();
        end
        i_valid = 1'b0;
        check("pre_rst_valid", o_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", o_valid, 0);
        check("midrst_res", o_res, 0);
        check("midrst_tag", o_tag, 0);
        q.delete();
        hold = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", o_ready, 1);
        for (int i = 0; i < 5; i++) begin
            check("no_stale", o_valid, 0);
            @(negedge clk);
        end
        tick();

        // Random traffic
        acc = 0;
        cyc = 0;
        while (acc < 3000 && cyc < 20000) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            i_a = rnd32(); i_b = rnd32();
            i_sub = $urandom_range(0, 1);
            i_tag = 4'($urandom);
            @(negedge clk);
            if (i_valid && o_ready) acc++;
            tick();
            cyc++;
        end
        check("random_accepted", acc, 3000);
        i_valid = 1'b0; i_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("drain_empty", q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
